// File: rtl/aes_soc_pkg.sv
// Shared constants and encodings for the PicoRV32 / SRAM / AES AXI4-Lite interconnect.
package aes_soc_pkg;

  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_SRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_SRAM_SIZE = 32'h0000_0800;
  localparam logic [31:0] DEF_AES_BASE  = 32'h1000_0000;
  localparam logic [31:0] DEF_AES_SIZE  = 32'h0000_0100;

  typedef enum logic [1:0] {
    SEL_SRAM = 2'd0,
    SEL_AES  = 2'd1,
    SEL_ERR  = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FWD  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FWD  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address window decode; SRAM takes priority when windows overlap.
module axi_addr_decode
  import aes_soc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] SRAM_BASE = ADDR_W'(DEF_SRAM_BASE),
  parameter logic [ADDR_W-1:0] SRAM_SIZE = ADDR_W'(DEF_SRAM_SIZE),
  parameter logic [ADDR_W-1:0] AES_BASE  = ADDR_W'(DEF_AES_BASE),
  parameter logic [ADDR_W-1:0] AES_SIZE  = ADDR_W'(DEF_AES_SIZE)
) (
  input  logic [ADDR_W-1:0] addr,
  output sel_e              sel
);

  logic hit_sram;
  logic hit_aes;

  assign hit_sram = (addr & ~(SRAM_SIZE - ADDR_W'(1))) == SRAM_BASE;
  assign hit_aes  = (addr & ~(AES_SIZE - ADDR_W'(1))) == AES_BASE;

  always_comb begin
    sel = SEL_ERR;
    if (hit_sram)     sel = SEL_SRAM;
    else if (hit_aes) sel = SEL_AES;
  end

endmodule

// File: rtl/axi_lite_addr_router.sv
// 1-master / 2-slave AXI4-Lite router: SRAM and AES windows, unmapped accesses answered locally.
//  state  | meaning
//  W_IDLE | no write in flight; AW decoded into sel_w when valid
//  W_FWD  | forwarding AW and W to the selected slave until both handshakes are done
//  W_RESP | passing B back; unmapped writes answer immediately
//  R_IDLE | no read in flight; AR decoded into sel_r when valid
//  R_FWD  | forwarding AR to the selected slave
//  R_RESP | passing R back; unmapped reads return zero data
module axi_lite_addr_router
  import aes_soc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] SRAM_BASE = ADDR_W'(DEF_SRAM_BASE),
  parameter logic [ADDR_W-1:0] SRAM_SIZE = ADDR_W'(DEF_SRAM_SIZE),
  parameter logic [ADDR_W-1:0] AES_BASE  = ADDR_W'(DEF_AES_BASE),
  parameter logic [ADDR_W-1:0] AES_SIZE  = ADDR_W'(DEF_AES_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_awvalid,
  output logic                m_awready,
  input  logic [ADDR_W-1:0]   m_awaddr,
  input  logic [2:0]          m_awprot,
  input  logic                m_wvalid,
  output logic                m_wready,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_bvalid,
  input  logic                m_bready,
  input  logic                m_arvalid,
  output logic                m_arready,
  input  logic [ADDR_W-1:0]   m_araddr,
  input  logic [2:0]          m_arprot,
  output logic                m_rvalid,
  input  logic                m_rready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                sram_awvalid,
  input  logic                sram_awready,
  output logic [ADDR_W-1:0]   sram_awaddr,
  output logic [2:0]          sram_awprot,
  output logic                sram_wvalid,
  input  logic                sram_wready,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic                sram_bvalid,
  output logic                sram_bready,
  output logic                sram_arvalid,
  input  logic                sram_arready,
  output logic [ADDR_W-1:0]   sram_araddr,
  output logic [2:0]          sram_arprot,
  input  logic                sram_rvalid,
  output logic                sram_rready,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                aes_awvalid,
  input  logic                aes_awready,
  output logic [ADDR_W-1:0]   aes_awaddr,
  output logic [2:0]          aes_awprot,
  output logic                aes_wvalid,
  input  logic                aes_wready,
  output logic [DATA_W-1:0]   aes_wdata,
  output logic [DATA_W/8-1:0] aes_wstrb,
  input  logic                aes_bvalid,
  output logic                aes_bready,
  output logic                aes_arvalid,
  input  logic                aes_arready,
  output logic [ADDR_W-1:0]   aes_araddr,
  output logic [2:0]          aes_arprot,
  input  logic                aes_rvalid,
  output logic                aes_rready,
  input  logic [DATA_W-1:0]   aes_rdata,
  output logic                sram_sel_aw,
  output logic                aes_sel_aw,
  output logic                dec_err
);

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;
  sel_e     aw_dec_sel, ar_dec_sel;
  sel_e     sel_w, sel_w_nxt, sel_r, sel_r_nxt;
  logic     aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic     fwd_awvalid, fwd_wvalid, fwd_bready, fwd_arvalid, fwd_rready;
  logic     tgt_awready, tgt_wready, tgt_bvalid, tgt_arready, tgt_rvalid;
  logic [DATA_W-1:0] tgt_rdata;
  logic     aw_err_hs, ar_err_hs;

  axi_addr_decode #(
    .ADDR_W(ADDR_W), .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
    .AES_BASE(AES_BASE), .AES_SIZE(AES_SIZE)
  ) u_aw_dec (.addr(m_awaddr), .sel(aw_dec_sel));

  axi_addr_decode #(
    .ADDR_W(ADDR_W), .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
    .AES_BASE(AES_BASE), .AES_SIZE(AES_SIZE)
  ) u_ar_dec (.addr(m_araddr), .sel(ar_dec_sel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      sel_w   <= SEL_ERR;
      sel_r   <= SEL_ERR;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      sel_w   <= sel_w_nxt;
      sel_r   <= sel_r_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Slave-side readys/valids of the currently selected target; zero when unmapped.
  always_comb begin
    tgt_awready = 1'b0;
    tgt_wready  = 1'b0;
    tgt_bvalid  = 1'b0;
    if (sel_w == SEL_SRAM) begin
      tgt_awready = sram_awready;
      tgt_wready  = sram_wready;
      tgt_bvalid  = sram_bvalid;
    end else if (sel_w == SEL_AES) begin
      tgt_awready = aes_awready;
      tgt_wready  = aes_wready;
      tgt_bvalid  = aes_bvalid;
    end
    tgt_arready = 1'b0;
    tgt_rvalid  = 1'b0;
    tgt_rdata   = '0;
    if (sel_r == SEL_SRAM) begin
      tgt_arready = sram_arready;
      tgt_rvalid  = sram_rvalid;
      tgt_rdata   = sram_rdata;
    end else if (sel_r == SEL_AES) begin
      tgt_arready = aes_arready;
      tgt_rvalid  = aes_rvalid;
      tgt_rdata   = aes_rdata;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    sel_w_nxt   = sel_w;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    fwd_awvalid = 1'b0;
    fwd_wvalid  = 1'b0;
    fwd_bready  = 1'b0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
    m_bvalid    = 1'b0;
    aw_err_hs   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (m_awvalid) begin
          sel_w_nxt   = aw_dec_sel;
          w_state_nxt = W_FWD;
        end
      end
      W_FWD: begin
        fwd_awvalid = m_awvalid & ~aw_done;
        fwd_wvalid  = m_wvalid & ~w_done;
        if (sel_w == SEL_ERR) begin
          m_awready = ~aw_done;
          m_wready  = ~w_done;
        end else begin
          m_awready = tgt_awready & ~aw_done;
          m_wready  = tgt_wready & ~w_done;
        end
        aw_done_nxt = aw_done | (m_awvalid & m_awready);
        w_done_nxt  = w_done | (m_wvalid & m_wready);
        aw_err_hs   = (sel_w == SEL_ERR) & m_awvalid & m_awready;
        if (aw_done_nxt && w_done_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        fwd_bready = m_bready;
        m_bvalid   = (sel_w == SEL_ERR) ? 1'b1 : tgt_bvalid;
        if (m_bvalid && m_bready) begin
          w_state_nxt = W_IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    sel_r_nxt   = sel_r;
    fwd_arvalid = 1'b0;
    fwd_rready  = 1'b0;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    ar_err_hs   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (m_arvalid) begin
          sel_r_nxt   = ar_dec_sel;
          r_state_nxt = R_FWD;
        end
      end
      R_FWD: begin
        fwd_arvalid = m_arvalid;
        m_arready   = (sel_r == SEL_ERR) ? 1'b1 : tgt_arready;
        ar_err_hs   = (sel_r == SEL_ERR) & m_arvalid;
        if (m_arvalid && m_arready) r_state_nxt = R_RESP;
      end
      R_RESP: begin
        fwd_rready = m_rready;
        m_rvalid   = (sel_r == SEL_ERR) ? 1'b1 : tgt_rvalid;
        m_rdata    = tgt_rdata;
        if (m_rvalid && m_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign sram_awvalid = fwd_awvalid & (sel_w == SEL_SRAM);
  assign sram_wvalid  = fwd_wvalid  & (sel_w == SEL_SRAM);
  assign sram_bready  = fwd_bready  & (sel_w == SEL_SRAM);
  assign sram_arvalid = fwd_arvalid & (sel_r == SEL_SRAM);
  assign sram_rready  = fwd_rready  & (sel_r == SEL_SRAM);
  assign aes_awvalid  = fwd_awvalid & (sel_w == SEL_AES);
  assign aes_wvalid   = fwd_wvalid  & (sel_w == SEL_AES);
  assign aes_bready   = fwd_bready  & (sel_w == SEL_AES);
  assign aes_arvalid  = fwd_arvalid & (sel_r == SEL_AES);
  assign aes_rready   = fwd_rready  & (sel_r == SEL_AES);

  assign sram_awaddr = m_awaddr;
  assign sram_awprot = m_awprot;
  assign sram_wdata  = m_wdata;
  assign sram_wstrb  = m_wstrb;
  assign sram_araddr = m_araddr;
  assign sram_arprot = m_arprot;
  assign aes_awaddr  = m_awaddr;
  assign aes_awprot  = m_awprot;
  assign aes_wdata   = m_wdata;
  assign aes_wstrb   = m_wstrb;
  assign aes_araddr  = m_araddr;
  assign aes_arprot  = m_arprot;

  assign sram_sel_aw = (w_state != W_IDLE) & (sel_w == SEL_SRAM);
  assign aes_sel_aw  = (w_state != W_IDLE) & (sel_w == SEL_AES);
  assign dec_err     = aw_err_hs | ar_err_hs;

endmodule

// File: tb/tb_axi_lite_addr_router.sv
// Scoreboard bench for axi_lite_addr_router: directed transactions, behavioural SRAM/AES slaves.
module tb_axi_lite_addr_router;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        sram_sel_aw, aes_sel_aw, dec_err;

  // index 0 = SRAM, 1 = AES
  logic        s_awvalid[2], s_awready[2], s_wvalid[2], s_wready[2], s_bvalid[2], s_bready[2];
  logic        s_arvalid[2], s_arready[2], s_rvalid[2], s_rready[2];
  logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
  logic [2:0]  s_awprot[2], s_arprot[2];
  logic [3:0]  s_wstrb[2];

  typedef struct {
    int          slv;
    logic [63:0] val;
  } ev_t;

  ev_t q_aw[$], q_w[$], q_ar[$], q_b[$], q_r[$];
  int  dec_exp = 0;
  int  dec_seen = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  axi_lite_addr_router dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .sram_awvalid(s_awvalid[0]), .sram_awready(s_awready[0]), .sram_awaddr(s_awaddr[0]),
    .sram_awprot(s_awprot[0]), .sram_wvalid(s_wvalid[0]), .sram_wready(s_wready[0]),
    .sram_wdata(s_wdata[0]), .sram_wstrb(s_wstrb[0]), .sram_bvalid(s_bvalid[0]),
    .sram_bready(s_bready[0]), .sram_arvalid(s_arvalid[0]), .sram_arready(s_arready[0]),
    .sram_araddr(s_araddr[0]), .sram_arprot(s_arprot[0]), .sram_rvalid(s_rvalid[0]),
    .sram_rready(s_rready[0]), .sram_rdata(s_rdata[0]),
    .aes_awvalid(s_awvalid[1]), .aes_awready(s_awready[1]), .aes_awaddr(s_awaddr[1]),
    .aes_awprot(s_awprot[1]), .aes_wvalid(s_wvalid[1]), .aes_wready(s_wready[1]),
    .aes_wdata(s_wdata[1]), .aes_wstrb(s_wstrb[1]), .aes_bvalid(s_bvalid[1]),
    .aes_bready(s_bready[1]), .aes_arvalid(s_arvalid[1]), .aes_arready(s_arready[1]),
    .aes_araddr(s_araddr[1]), .aes_arprot(s_arprot[1]), .aes_rvalid(s_rvalid[1]),
    .aes_rready(s_rready[1]), .aes_rdata(s_rdata[1]),
    .sram_sel_aw(sram_sel_aw), .aes_sel_aw(aes_sel_aw), .dec_err(dec_err)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_snapshot();
    return 64'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid, sram_sel_aw, aes_sel_aw,
                dec_err, s_awvalid[0], s_awvalid[1], s_wvalid[0], s_wvalid[1], s_bready[0],
                s_bready[1], s_arvalid[0], s_arvalid[1], s_rready[0], s_rready[1], m_rdata});
  endfunction

  // Behavioural slaves: random AW/W/AR ready, B after both beats, R after a fixed stall.
  bit          hs_aw[2], hs_w[2], hs_ar[2], hs_b[2], hs_r[2];
  bit          have_aw[2], have_w[2], pend_r[2];
  int          rcnt[2];
  logic [31:0] sv_waddr[2], sv_wdata[2], sv_raddr[2];
  logic [3:0]  sv_wstrb[2];
  logic [31:0] smem[2][64];

  initial begin
    for (int g = 0; g < 2; g++) begin
      s_awready[g] = 1'b0; s_wready[g] = 1'b0; s_arready[g] = 1'b0;
      s_bvalid[g] = 1'b0; s_rvalid[g] = 1'b0; s_rdata[g] = '0;
      have_aw[g] = 0; have_w[g] = 0; pend_r[g] = 0; rcnt[g] = 0;
      for (int i = 0; i < 64; i++) smem[g][i] = 32'hA000_0000 | (32'(g) << 16) | 32'(i);
    end
    smem[1][1] = 32'h1234_5678;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        hs_aw[g] = s_awvalid[g] && s_awready[g];
        hs_w[g]  = s_wvalid[g] && s_wready[g];
        hs_ar[g] = s_arvalid[g] && s_arready[g];
        hs_b[g]  = s_bvalid[g] && s_bready[g];
        hs_r[g]  = s_rvalid[g] && s_rready[g];
        if (hs_aw[g]) sv_waddr[g] = s_awaddr[g];
        if (hs_w[g]) begin sv_wdata[g] = s_wdata[g]; sv_wstrb[g] = s_wstrb[g]; end
        if (hs_ar[g]) sv_raddr[g] = s_araddr[g];
      end
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          have_aw[g] = 0; have_w[g] = 0; pend_r[g] = 0;
          s_bvalid[g] = 1'b0; s_rvalid[g] = 1'b0; s_rdata[g] = '0;
        end else begin
          if (hs_b[g]) s_bvalid[g] = 1'b0;
          if (hs_r[g]) begin s_rvalid[g] = 1'b0; s_rdata[g] = '0; end
          if (hs_aw[g]) have_aw[g] = 1;
          if (hs_w[g]) have_w[g] = 1;
          if (have_aw[g] && have_w[g] && !s_bvalid[g]) begin
            for (int b = 0; b < 4; b++)
              if (sv_wstrb[g][b]) smem[g][sv_waddr[g][7:2]][8*b +: 8] = sv_wdata[g][8*b +: 8];
            s_bvalid[g] = 1'b1;
            have_aw[g] = 0;
            have_w[g] = 0;
          end
          if (hs_ar[g]) begin pend_r[g] = 1; rcnt[g] = (g == 1) ? 3 : 1; end
          if (pend_r[g] && !s_rvalid[g]) begin
            if (rcnt[g] == 0) begin
              s_rvalid[g] = 1'b1;
              s_rdata[g]  = smem[g][sv_raddr[g][7:2]];
              pend_r[g]   = 0;
            end else rcnt[g]--;
          end
        end
        s_awready[g] = 1'($urandom_range(0, 1));
        s_wready[g]  = 1'($urandom_range(0, 1));
        s_arready[g] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every handshake seen on the slave or master side pops and checks one expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int g = 0; g < 2; g++) begin
          if (s_awvalid[g] && s_awready[g]) begin
            chk("aw_expected", 64'(q_aw.size() != 0), 1);
            if (q_aw.size() != 0) begin
              e = q_aw.pop_front();
              chk("aw_slave", 64'(g), 64'(e.slv));
              chk("aw_prot_addr", 64'({s_awprot[g], s_awaddr[g]}), e.val);
            end
          end
          if (s_wvalid[g] && s_wready[g]) begin
            chk("w_expected", 64'(q_w.size() != 0), 1);
            if (q_w.size() != 0) begin
              e = q_w.pop_front();
              chk("w_slave", 64'(g), 64'(e.slv));
              chk("w_strb_data", 64'({s_wstrb[g], s_wdata[g]}), e.val);
            end
          end
          if (s_arvalid[g] && s_arready[g]) begin
            chk("ar_expected", 64'(q_ar.size() != 0), 1);
            if (q_ar.size() != 0) begin
              e = q_ar.pop_front();
              chk("ar_slave", 64'(g), 64'(e.slv));
              chk("ar_prot_addr", 64'({s_arprot[g], s_araddr[g]}), e.val);
            end
          end
        end
        if (m_bvalid && m_bready) begin
          chk("b_expected", 64'(q_b.size() != 0), 1);
          if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_sel_strobes", 64'({sram_sel_aw, aes_sel_aw}), e.val);
          end
        end
        if (m_rvalid && m_rready) begin
          chk("r_expected", 64'(q_r.size() != 0), 1);
          if (q_r.size() != 0) begin
            e = q_r.pop_front();
            chk("r_data", 64'(m_rdata), e.val);
          end
        end
        if (dec_err) begin
          chk("dec_err_expected", 64'(dec_seen < dec_exp), 1);
          dec_seen++;
        end
      end
    end
  end

  task automatic do_aw(logic [31:0] a, logic [2:0] p);
    int n = 0;
    bit got = 0;
    m_awvalid = 1'b1; m_awaddr = a; m_awprot = p;
    while (!got && n < TMO) begin
      @(negedge clk); got = m_awready; n++;
      @(posedge clk); #1;
    end
    m_awvalid = 1'b0;
    chk("aw_handshake_in_time", 64'(got), 1);
  endtask

  task automatic do_w(logic [31:0] d, logic [3:0] s);
    int n = 0;
    bit got = 0;
    m_wvalid = 1'b1; m_wdata = d; m_wstrb = s;
    while (!got && n < TMO) begin
      @(negedge clk); got = m_wready; n++;
      @(posedge clk); #1;
    end
    m_wvalid = 1'b0;
    chk("w_handshake_in_time", 64'(got), 1);
  endtask

  task automatic do_ar(logic [31:0] a, logic [2:0] p);
    int n = 0;
    bit got = 0;
    m_arvalid = 1'b1; m_araddr = a; m_arprot = p;
    while (!got && n < TMO) begin
      @(negedge clk); got = m_arready; n++;
      @(posedge clk); #1;
    end
    m_arvalid = 1'b0;
    chk("ar_handshake_in_time", 64'(got), 1);
  endtask

  task automatic wait_b(bit bp);
    int n = 0;
    bit got = 0;
    while (!got && n < TMO) begin
      m_bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); got = m_bvalid && m_bready; n++;
      @(posedge clk); #1;
    end
    m_bready = 1'b0;
    chk("b_handshake_in_time", 64'(got), 1);
  endtask

  task automatic wait_r(bit bp);
    int n = 0;
    bit got = 0;
    while (!got && n < TMO) begin
      m_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); got = m_rvalid && m_rready; n++;
      @(posedge clk); #1;
    end
    m_rready = 1'b0;
    chk("r_handshake_in_time", 64'(got), 1);
  endtask

  // slv: 0 = SRAM, 1 = AES, 2 = unmapped; w_lead = cycles W is presented ahead of AW
  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s, int slv, int w_lead, bit bp);
    if (slv < 2) begin
      q_aw.push_back('{slv, 64'({3'b010, a})});
      q_w.push_back('{slv, 64'({s, d})});
    end else dec_exp++;
    q_b.push_back('{slv, (slv == 0) ? 64'd2 : (slv == 1) ? 64'd1 : 64'd0});
    fork
      do_w(d, s);
      begin
        repeat (w_lead) begin @(posedge clk); #1; end
        do_aw(a, 3'b010);
      end
    join
    if (slv == 2) begin
      @(negedge clk);
      chk("err_bvalid_immediate", 64'(m_bvalid), 1);
      @(posedge clk); #1;
    end
    wait_b(bp);
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] exp_d, int slv, bit bp);
    if (slv < 2) q_ar.push_back('{slv, 64'({3'b001, a})});
    else dec_exp++;
    q_r.push_back('{slv, 64'(exp_d)});
    do_ar(a, 3'b001);
    wait_r(bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_awvalid = 0; m_awaddr = '0; m_awprot = '0; m_wvalid = 0; m_wdata = '0; m_wstrb = '0;
    m_bready = 0; m_arvalid = 0; m_araddr = '0; m_arprot = '0; m_rready = 0;
    @(negedge clk);
    chk("reset_outputs_zero", outs_snapshot(), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs_zero", outs_snapshot(), 0);
    @(posedge clk); #1;

    // 1: SRAM write, then partial-strobe write and read-backs
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    wr(32'h0000_0014, 32'h5555_AAAA, 4'h3, 0, 0, 0);
    rd(32'h0000_0014, 32'hA000_AAAA, 0, 0);
    // 2: AES read with slave stall
    rd(32'h1000_0004, 32'h1234_5678, 1, 0);
    // window boundaries
    rd(32'h0000_07FC, 32'hA000_003F, 0, 0);
    rd(32'h0000_0800, 32'h0000_0000, 2, 0);
    rd(32'h1000_00FC, 32'hA001_003F, 1, 0);
    rd(32'h1000_0100, 32'h0000_0000, 2, 0);
    // 3: unmapped write and read
    wr(32'h2000_0000, 32'h0000_0000, 4'hF, 2, 0, 0);
    rd(32'h2000_0000, 32'h0000_0000, 2, 0);
    // 4: W two cycles ahead of AW, then AW/W together
    wr(32'h1000_0020, 32'h0102_0304, 4'hF, 1, 2, 0);
    wr(32'h0000_0030, 32'h0A0B_0C0D, 4'hF, 0, 0, 0);
    rd(32'h1000_0020, 32'h0102_0304, 1, 0);
    // 5: concurrent SRAM read + AES write with master backpressure
    fork
      rd(32'h0000_0010, 32'hDEAD_BEEF, 0, 1);
      wr(32'h1000_0008, 32'hCAFE_F00D, 4'hF, 1, 0, 1);
    join
    fork
      rd(32'h1000_0008, 32'hCAFE_F00D, 1, 1);
      wr(32'h0000_0040, 32'h7777_8888, 4'hF, 0, 1, 1);
    join
    rd(32'h0000_0040, 32'h7777_8888, 0, 1);

    // 6: reset while the write sits in W_RESP
    q_aw.push_back('{0, 64'({3'b010, 32'h0000_0020})});
    q_w.push_back('{0, 64'({4'hF, 32'h1357_9BDF})});
    fork
      do_aw(32'h0000_0020, 3'b010);
      do_w(32'h1357_9BDF, 4'hF);
    join
    chk("w_resp_sram_sel", 64'({sram_sel_aw, aes_sel_aw}), 64'd2);
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk);
    #2 reset = 1'b1; m_bready = 1'b1; m_rready = 1'b1;
    @(negedge clk);
    chk("mid_txn_reset_outputs_zero", outs_snapshot(), 0);
    @(posedge clk);
    #2 reset = 1'b0; m_bready = 1'b0; m_rready = 1'b0;
    @(posedge clk); #1;
    wr(32'h0000_0024, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    rd(32'h0000_0024, 32'h0BAD_F00D, 0, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("aw_queue_drained", 64'(q_aw.size()), 0);
    chk("w_queue_drained", 64'(q_w.size()), 0);
    chk("ar_queue_drained", 64'(q_ar.size()), 0);
    chk("b_queue_drained", 64'(q_b.size()), 0);
    chk("r_queue_drained", 64'(q_r.size()), 0);
    chk("dec_err_pulse_count", 64'(dec_seen), 64'(dec_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
